// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   XLEN            operand/result width (only 32 is supported)
//   muldiv_op_e     RISC-V funct3 encodings of the M-extension operations
//   muldiv_state_e  control FSM states
//   ALL_ONES        divide-by-zero quotient value
//   INT_MIN         most negative XLEN-bit value (signed overflow dividend)
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the shared multiply/divide datapath.
// The working pair {hi, lo} is a 2*XLEN register.
//   is_div   in   1     0: shift-add multiply step, 1: restoring divide step
//   hi       in   XLEN  multiply: partial product high word; divide: partial remainder
//   lo       in   XLEN  multiply: remaining multiplier bits; divide: dividend/quotient bits
//   addend   in   XLEN  multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_next  out  XLEN  updated high word
//   lo_next  out  XLEN  updated low word
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] addend,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        // Multiply: conditionally add multiplicand into the high word, keeping the carry,
        // then shift the whole {carry, hi, lo} right by one.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
        // Divide: bring the next dividend bit into the partial remainder.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, addend};
        // An explicit compare (rather than the borrow bit) keeps a zero divisor
        // producing all-ones quotient bits and passing the dividend through.
        fits    = (shifted >= {1'b0, addend});

        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (fits) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (mul, mulh, mulhsu, mulhu,
// div, divu, rem, remu). Operands are reduced to magnitudes on accept, one
// shift-add or restoring shift-subtract step runs per cycle for XLEN cycles,
// then the sign is restored and the requested word is registered.
//   clk       in   1     rising-edge clock
//   reset     in   1     synchronous active-high reset
//   start     in   1     request strobe, only sampled while idle
//   op        in   3     RISC-V funct3 of the operation
//   operand1  in   XLEN  rs1 (multiplicand / dividend)
//   operand2  in   XLEN  rs2 (multiplier / divisor)
//   busy      out  1     high whenever not idle
//   done      out  1     one-cycle pulse, result valid
//   result    out  XLEN  registered result, held until the next completion
// Build option: MULDIV_FASTPATH_EN -- divide-by-zero and signed overflow finish
// directly from idle instead of running the iterative path.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e   state_reg, state_next;
    logic [5:0]      count_reg;
    muldiv_op_e      op_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, addend_reg;
    logic            neg_reg;      // product / quotient must be negated
    logic            rem_neg_reg;  // remainder takes the dividend's sign
    logic [XLEN-1:0] result_reg;

    logic [XLEN-1:0] hi_next, lo_next;

    // ---------------- operand pre-processing ----------------
    muldiv_op_e      op_in;
    logic            is_div_in;
    logic            a_signed, b_signed, a_neg, b_neg, div_zero, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        op_in     = muldiv_op_e'(op);
        is_div_in = op[2];
        // The low word of a product is the same for any signedness, so mul runs unsigned.
        a_signed  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_signed  = (op_in inside {OP_MULH, OP_DIV, OP_REM});
        a_neg     = a_signed & operand1[XLEN-1];
        b_neg     = b_signed & operand2[XLEN-1];
        mag_a     = a_neg ? -operand1 : operand1;
        mag_b     = b_neg ? -operand2 : operand2;
        div_zero  = (operand2 == '0);
        // A zero divisor yields all-ones regardless of the dividend's sign, so the
        // quotient is never negated in that case.
        neg_in    = (a_neg ^ b_neg) & ~(is_div_in & div_zero);
    end

`ifdef MULDIV_FASTPATH_EN
    logic            overflow_in, fast_in;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        overflow_in = (op_in inside {OP_DIV, OP_REM}) &&
                      (operand1 == INT_MIN) && (operand2 == ALL_ONES);
        fast_in     = is_div_in & (div_zero | overflow_in);
        // op[1] distinguishes rem/remu from div/divu.
        if (div_zero) begin
            fast_result = op[1] ? operand1 : ALL_ONES;
        end else begin
            fast_result = op[1] ? '0 : INT_MIN;
        end
    end
`endif

    // ---------------- shared iteration step ----------------
    muldiv_iter u_iter (
        .is_div  (op_reg[2]),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .addend  (addend_reg),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // ---------------- sign correction and output select ----------------
    logic [2*XLEN-1:0] prod, prod_fixed;
    logic [XLEN-1:0]   quot_fixed, rem_fixed, fix_result;

    always_comb begin
        prod       = {hi_reg, lo_reg};
        prod_fixed = neg_reg ? -prod : prod;
        quot_fixed = neg_reg ? -lo_reg : lo_reg;
        rem_fixed  = rem_neg_reg ? -hi_reg : hi_reg;
        fix_result = prod_fixed[XLEN-1:0];
        case (op_reg)
            OP_MUL:                         fix_result = prod_fixed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_result = prod_fixed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_result = quot_fixed;
            OP_REM, OP_REMU:                fix_result = rem_fixed;
            default:                        fix_result = prod_fixed[XLEN-1:0];
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
`ifdef MULDIV_FASTPATH_EN
                    state_next = fast_in ? ST_DONE : ST_CALC;
`else
                    state_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (count_reg == 6'(XLEN-1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= '0;
            op_reg      <= OP_MUL;
            hi_reg      <= '0;
            lo_reg      <= '0;
            addend_reg  <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg      <= op_in;
                        count_reg   <= '0;
                        hi_reg      <= '0;
                        // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
                        lo_reg      <= is_div_in ? mag_a : mag_b;
                        addend_reg  <= is_div_in ? mag_b : mag_a;
                        neg_reg     <= neg_in;
                        rem_neg_reg <= a_neg;
`ifdef MULDIV_FASTPATH_EN
                        if (fast_in) begin
                            result_reg <= fast_result;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    count_reg <= count_reg + 6'd1;
                end
                ST_FIX: begin
                    result_reg <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Stimulus pushes the expected
// result (from a plain-arithmetic RV32M model) and expected latency into a queue;
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1, operand2;
    logic        busy, done;
    logic [31:0] result;

    // Latency measured as edges from the accepting edge to the edge that raises done.
`ifdef MULDIV_FASTPATH_EN
    localparam int FAST_LAT = 0;
`else
    localparam int FAST_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          e;
        int          lat;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   total = 0;
    int   bad = 0;
    bit   busy_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: busy must stay high from the accepting edge through the done cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && cyc >= sb_q[0].e && busy !== 1'b1) busy_gap = 1'b1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 result=%h expected no completion", result);
            end else begin
                mon_x = sb_q.pop_front();
                $display("txn op=%0d a=%h b=%h result=%h expect=%h lat=%0d",
                         mon_x.op, mon_x.a, mon_x.b, result, mon_x.res, cyc - mon_x.e);
                check("result", result, mon_x.res);
                check("latency", 32'(cyc - mon_x.e), 32'(mon_x.lat));
                check("busy_held", {31'b0, busy_gap}, 32'd0);
                busy_gap = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d expected idle", busy, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        wait_idle();
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        x.res = ref_model(o, a, b);
        x.e   = cyc + 1;
        x.lat = is_fast(o, a, b) ? FAST_LAT : FULL_LAT;
        x.op  = o;
        x.a   = a;
        x.b   = b;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 3'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            4:       return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; operand1 = '0; operand2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2);
        issue(3'd7, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, 32'hFFFF_FFFB, 32'd0);
        issue(3'd6, 32'hFFFF_FFFB, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Second start mid-CALC must be ignored.
        issue(3'd0, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd5; operand1 = 32'd99; operand2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;

        // Reset ten cycles into an operation.
        issue(3'd5, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        busy_gap = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("postreset_result", result, 32'd0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
